axi_burst_ram: RTL and testbench

AXI4 memory responder (slave) that services INCR bursts from AXI initiators such as the CDMA engine; it is the target end of the same AXI read/write interface. It has independent write (AW/W/B) and read (AR/R) engines over a dual-port word array, so one read burst and one write burst can proceed concurrently.

---
 rtl/axi_burst_ram_pkg.sv | 28 ++
 rtl/axi_burst_ram_rd.sv | 149 ++++++++++++++
 rtl/axi_burst_ram.sv | 211 +++++++++++++++++++++
 tb/tb_axi_burst_ram.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_ram_pkg.sv
// Shared definitions for the AXI4 burst RAM responder: response codes,
// FSM state types and the decode-error build switch.
// Optional build macro: AXI_BURST_RAM_DECERR_EN -- when defined, beats whose
// byte address lies above the array range answer DECERR instead of aliasing.
package axi_burst_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_BURST_RAM_DECERR_EN
    localparam logic DECERR_EN = 1'b1;
`else
    localparam logic DECERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

endpackage

// File: rtl/axi_burst_ram_rd.sv
// Read engine of the AXI4 burst RAM: accepts one AR burst at a time and
// streams words out through a single registered R stage.
// The word is fetched into the output register whenever that register is
// empty or its current beat is being accepted, giving one beat per cycle.
// Optional build macro: AXI_BURST_RAM_DECERR_EN (see axi_burst_ram_pkg).
module axi_burst_ram_rd
    import axi_burst_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int OFFS = $clog2(STRB_WIDTH);
    localparam int WA_W = ADDR_WIDTH - OFFS;
    localparam logic [WA_W-1:0] WA_ONE = {{(WA_W-1){1'b0}}, 1'b1};

    rd_state_e             state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [WA_W-1:0]       waddr_q, waddr_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  fetch_s;
    logic                  dec_err_s;
    logic                  unused_s;

    // Next-state logic: AR acceptance, word fetch into the output stage, burst end.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        waddr_d   = waddr_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        dec_err_s = DECERR_EN && ((waddr_q >> MEM_ADDR_WIDTH) != {WA_W{1'b0}});
        fetch_s   = (state_q == R_DATA) && (cnt_q != 9'd0) && (!rvalid_q || s_axi_rready);
        case (state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    state_d   = R_DATA;
                    id_d      = s_axi_arid;
                    waddr_d   = s_axi_araddr[ADDR_WIDTH-1:OFFS];
                    cnt_d     = {1'b0, s_axi_arlen} + 9'd1;
                    arready_d = 1'b0;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                arready_d = 1'b0;
                if (fetch_s) begin
                    rvalid_d = 1'b1;
                    rid_d    = id_q;
                    rlast_d  = (cnt_q == 9'd1);
                    waddr_d  = waddr_q + WA_ONE;
                    cnt_d    = cnt_q - 9'd1;
                    if (dec_err_s) begin
                        rdata_d = {DATA_WIDTH{1'b0}};
                        rresp_d = RESP_DECERR;
                    end else begin
                        rdata_d = mem_rdata;
                        rresp_d = RESP_OKAY;
                    end
                end else if (rvalid_q && s_axi_rready) begin
                    rvalid_d = 1'b0;
                end else begin
                    rvalid_d = rvalid_q;
                end
                // the last beat leaves the register on this edge; return to idle
                if (rvalid_q && s_axi_rready && rlast_q) begin
                    state_d   = R_IDLE;
                    arready_d = 1'b1;
                end else begin
                    state_d = R_DATA;
                end
            end
            default: begin
                state_d   = R_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= R_IDLE;
            id_q      <= {ID_WIDTH{1'b0}};
            waddr_q   <= {WA_W{1'b0}};
            cnt_q     <= 9'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= {ID_WIDTH{1'b0}};
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            waddr_q   <= waddr_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign mem_raddr     = waddr_q[MEM_ADDR_WIDTH-1:0];
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    // sub-word address bits carry no information for full-width transfers
    assign unused_s      = ^s_axi_araddr;

endmodule

// File: rtl/axi_burst_ram.sv
// AXI4 INCR-burst memory responder. The write engine (AW/W/B) lives here,
// the read engine is axi_burst_ram_rd; both share one word array so a read
// burst and a write burst can run concurrently. A read and a write of the
// same word on the same edge return the old contents.
// Optional build macro: AXI_BURST_RAM_DECERR_EN (see axi_burst_ram_pkg).
module axi_burst_ram
    import axi_burst_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int OFFS  = $clog2(STRB_WIDTH);
    localparam int WA_W  = ADDR_WIDTH - OFFS;
    localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
    localparam logic [WA_W-1:0] WA_ONE = {{(WA_W-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

    wr_state_e                 wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]       wid_q, wid_d;
    logic [WA_W-1:0]           waddr_q, waddr_d;
    logic [7:0]                wcnt_q, wcnt_d;
    logic                      werr_q, werr_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]       bid_q, bid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      wbeat_s;
    logic                      wdec_s;
    logic                      mem_we_s;
    logic [MEM_ADDR_WIDTH-1:0] rd_idx_s;
    logic [DATA_WIDTH-1:0]     rd_word_s;
    logic                      unused_s;

    // Write FSM next-state: AW acceptance, per-beat address/count, B response.
    always_comb begin
        wstate_d  = wstate_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        wbeat_s   = (wstate_q == W_DATA) && wready_q && s_axi_wvalid;
        wdec_s    = DECERR_EN && ((waddr_q >> MEM_ADDR_WIDTH) != {WA_W{1'b0}});
        mem_we_s  = wbeat_s && !wdec_s;
        case (wstate_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    wstate_d  = W_DATA;
                    wid_d     = s_axi_awid;
                    waddr_d   = s_axi_awaddr[ADDR_WIDTH-1:OFFS];
                    wcnt_d    = s_axi_awlen;
                    werr_d    = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                end else begin
                    awready_d = 1'b1;
                end
            end
            W_DATA: begin
                if (wbeat_s) begin
                    waddr_d = waddr_q + WA_ONE;
                    wcnt_d  = wcnt_q - 8'd1;
                    werr_d  = werr_q || wdec_s;
                    // burst length comes from awlen alone; wlast is ignored
                    if (wcnt_q == 8'd0) begin
                        wstate_d = W_RESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = wid_q;
                        if (werr_q || wdec_s) begin
                            bresp_d = RESP_DECERR;
                        end else begin
                            bresp_d = RESP_OKAY;
                        end
                    end else begin
                        wstate_d = W_DATA;
                    end
                end else begin
                    wstate_d = W_DATA;
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end else begin
                    wstate_d = W_RESP;
                end
            end
            default: begin
                wstate_d  = W_IDLE;
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // Write FSM registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q  <= W_IDLE;
            wid_q     <= {ID_WIDTH{1'b0}};
            waddr_q   <= {WA_W{1'b0}};
            wcnt_q    <= 8'd0;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= {ID_WIDTH{1'b0}};
            bresp_q   <= RESP_OKAY;
        end else begin
            wstate_q  <= wstate_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-masked array write; the contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[waddr_q[MEM_ADDR_WIDTH-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // the read engine registers this word, so a same-edge write is not seen
    assign rd_word_s = mem_q[rd_idx_s];

    axi_burst_ram_rd #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .STRB_WIDTH     (STRB_WIDTH),
        .ID_WIDTH       (ID_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_rd (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .mem_raddr     (rd_idx_s),
        .mem_rdata     (rd_word_s)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    // wlast and the sub-word address bits carry no information here
    assign unused_s      = ^{s_axi_wlast, s_axi_awaddr};

endmodule

// File: tb/tb_axi_burst_ram.sv
// Self-checking bench for axi_burst_ram: a table of single-beat write/read
// vectors, then hand-written burst, stall, wrap and concurrency sequences.
// Expected read beats and B responses go into scoreboard queues when the
// request is issued and are popped when the DUT answers.
module tb_axi_burst_ram;

`ifdef AXI_BURST_RAM_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  awid;
    logic [15:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [7:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [7:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid, arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    axi_burst_ram dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] data; logic last; logic [7:0] id; logic [1:0] resp; } rexp_t;
    typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
    typedef struct {
        logic [7:0]  id;
        logic [15:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [15:0] raddr;
        logic [31:0] rdat;
        logic [1:0]  rresp;
    } vec_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] wbuf [0:255];
    logic [31:0] rexp_data [0:255];
    vec_t        vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Full write transaction, entered and left on a falling edge.
    task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        bexp_t e;
        int    n;
        e.id = id;
        e.resp = exp_resp;
        bq.push_back(e);
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 200) begin @(negedge clk); n++; end
        if (!awready) begin timeout_fail("aw_handshake"); awvalid = 1'b0; bq.delete(); return; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 200) begin @(negedge clk); n++; end
            if (!wready) begin timeout_fail("w_handshake"); wvalid = 1'b0; bq.delete(); return; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 200) begin @(negedge clk); n++; end
        if (!bvalid) begin timeout_fail("b_response"); bready = 1'b0; bq.delete(); return; end
        e = bq.pop_front();
        chk("bid", {24'd0, bid}, {24'd0, e.id});
        chk("bresp", {30'd0, bresp}, {30'd0, e.resp});
        @(negedge clk);
        bready = 1'b0;
    endtask

    // Full read transaction; toggle=1 drives rready 1,0,1,0... from the first data cycle.
    task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input bit toggle, input logic [1:0] exp_resp);
        rexp_t       e;
        int          n, cyc, beats, first, last;
        logic        stall;
        logic [31:0] held;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = rexp_data[i]; e.last = (i == int'(len)); e.id = id; e.resp = exp_resp;
            rq.push_back(e);
        end
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 200) begin @(negedge clk); n++; end
        if (!arready) begin timeout_fail("ar_handshake"); arvalid = 1'b0; rq.delete(); return; end
        @(negedge clk);
        arvalid = 1'b0;
        chk("r_not_yet_valid", {31'd0, rvalid}, 32'd0);
        cyc = 0; beats = 0; first = -1; last = -1; stall = 1'b0; held = 32'd0;
        while (beats <= int'(len) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            rready = toggle ? cyc[0] : 1'b1;
            if (stall) begin
                chk("r_stall_valid", {31'd0, rvalid}, 32'd1);
                chk("r_stall_data", rdata, held);
            end
            if (rvalid && rready) begin
                e = rq.pop_front();
                chk("rdata", rdata, e.data);
                chk("rlast", {31'd0, rlast}, {31'd0, e.last});
                chk("rid", {24'd0, rid}, {24'd0, e.id});
                chk("rresp", {30'd0, rresp}, {30'd0, e.resp});
                if (first < 0) first = cyc;
                last = cyc;
                beats++;
            end
            stall = rvalid && !rready;
            held = rdata;
        end
        if (beats <= int'(len)) begin timeout_fail("r_beats"); rq.delete(); end
        @(negedge clk);
        rready = 1'b0;
        chk("r_no_extra_beat", {31'd0, rvalid}, 32'd0);
        chk("r_first_latency", first, 32'd1);
        if (!toggle) chk("r_throughput", last - first, {24'd0, len});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        awid = 8'd0; awaddr = 16'd0; awlen = 8'd0; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = 8'd0; araddr = 16'd0; arlen = 8'd0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ids", {16'd0, bid, rid}, 32'd0);
        chk("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_awready", {31'd0, awready}, 32'd1);
        chk("idle_arready", {31'd0, arready}, 32'd1);

        // Single-beat vectors: write, then read back one word
        vecs[0] = '{8'h5A, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0010, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{8'h11, 16'h0020, 32'hAAAAAAAA, 4'hF, 2'b00, 16'h0020, 32'hAAAAAAAA, 2'b00};
        vecs[2] = '{8'h12, 16'h0020, 32'h11223344, 4'h6, 2'b00, 16'h0020, 32'hAA2233AA, 2'b00};
        vecs[3] = '{8'h13, 16'h0020, 32'h55000066, 4'h9, 2'b00, 16'h0020, 32'h55223366, 2'b00};
        vecs[4] = '{8'h14, 16'h0013, 32'hCAFEF00D, 4'hF, 2'b00, 16'h0010, 32'hCAFEF00D, 2'b00};
        vecs[5] = '{8'h15, 16'h0010, 32'h00000000, 4'h0, 2'b00, 16'h0010, 32'hCAFEF00D, 2'b00};
        vecs[6] = '{8'h16, 16'h0000, 32'h01020304, 4'hF, 2'b00, 16'h0000, 32'h01020304, 2'b00};
        vecs[7] = '{8'h17, 16'h8000, 32'h0BADF00D, 4'hF, DEC ? 2'b11 : 2'b00,
                    16'h0000, DEC ? 32'h01020304 : 32'h0BADF00D, 2'b00};
        vecs[8] = '{8'h18, 16'h0FFC, 32'h77777777, 4'hF, 2'b00,
                    16'h8000, DEC ? 32'h00000000 : 32'h0BADF00D, DEC ? 2'b11 : 2'b00};
        vecs[9] = '{8'h19, 16'h3FFC, 32'h13579BDF, 4'hF, 2'b00, 16'h3FFC, 32'h13579BDF, 2'b00};
        for (int v = 0; v < 10; v++) begin
            wbuf[0] = vecs[v].wdat;
            axi_write(vecs[v].id, vecs[v].waddr, 8'd0, vecs[v].strb, vecs[v].bresp);
            rexp_data[0] = vecs[v].rdat;
            axi_read(vecs[v].id + 8'h80, vecs[v].raddr, 8'd0, 1'b0, vecs[v].rresp);
        end

        // Burst crossing the top of the array: wraps, or is a sticky decode error
        wbuf[0] = 32'hA0A0A0A0;
        wbuf[1] = 32'hB1B1B1B1;
        axi_write(8'h30, 16'h3FFC, 8'd1, 4'hF, DEC ? 2'b11 : 2'b00);
        rexp_data[0] = DEC ? 32'h01020304 : 32'hB1B1B1B1;
        axi_read(8'h31, 16'h0000, 8'd0, 1'b0, 2'b00);
        rexp_data[0] = 32'hA0A0A0A0;
        axi_read(8'h32, 16'h3FFC, 8'd0, 1'b0, 2'b00);

        // 16-beat burst, full-rate readback
        for (int i = 0; i < 16; i++) begin wbuf[i] = i; rexp_data[i] = i; end
        axi_write(8'h21, 16'h0100, 8'd15, 4'hF, 2'b00);
        axi_read(8'h22, 16'h0100, 8'd15, 1'b0, 2'b00);

        // 8-beat burst read back with rready toggling
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'h10000000 + i;
            rexp_data[i] = 32'h10000000 + i;
        end
        axi_write(8'h23, 16'h0200, 8'd7, 4'hF, 2'b00);
        axi_read(8'h24, 16'h0200, 8'd7, 1'b1, 2'b00);

        // Concurrent write burst and read burst on disjoint ranges
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h20000000 + i;
        for (int i = 0; i < 16; i++) rexp_data[i] = i;
        fork
            axi_write(8'h41, 16'h0400, 8'd7, 4'hF, 2'b00);
            axi_read(8'h42, 16'h0100, 8'd15, 1'b0, 2'b00);
        join
        for (int i = 0; i < 8; i++) rexp_data[i] = 32'h20000000 + i;
        axi_read(8'h43, 16'h0400, 8'd7, 1'b0, 2'b00);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
